ag2048_tiny_calculator: RTL and testbench

//  Top level of an 8-bit four-function keypad calculator (Tiny Tapeout wrapper pinout).
//  - Scans a 4x4 hex keypad.
//  - Takes op/eq/AC/neg buttons.
//  - Drives four 7-seg digits through a serial shift-register chain, plus four op-state LEDs.

---
 rtl/ag2048_calc_pkg.sv | 62 ++++++
 rtl/calc_sr_driver.sv | 73 +++++++
 rtl/ag2048_tiny_calculator.sv | 221 ++++++++++++++++++++++
 tb/tb_ag2048_tiny_calculator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ag2048_calc_pkg.sv
// ag2048 tiny calculator: shared types and constants.
// States, operators and 7-segment glyphs.
package ag2048_calc_pkg;

  typedef enum logic [1:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_RESULT
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  localparam logic [7:0] SEG_MINUS = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Glyph bit order a..g,dp from MSB to LSB.
  function automatic logic [7:0] seg_hex(
    input logic [3:0] v
  );
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] op_led(
    input op_e o
  );
    logic [3:0] l;
    unique case (o)
      OP_ADD:  l = 4'b0001;
      OP_SUB:  l = 4'b0010;
      OP_MUL:  l = 4'b0100;
      OP_DIV:  l = 4'b1000;
      default: l = 4'b0000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/calc_sr_driver.sv
// Serializes a 32-bit display frame into a shift-register chain.
// MSB first, 2 clocks per bit, one latch clock per frame.
module calc_sr_driver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] frame_i,
  output logic        sr_data_o,
  output logic        sr_clk_o,
  output logic        sr_latch_o,
  output logic        sr_oe_n_o
);

  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic        data_q, data_d;
  logic        sclk_q, sclk_d;
  logic        latch_q, latch_d;
  logic        oe_n_q, oe_n_d;

  // Slot 0 snapshots the frame, odd slots raise sr_clk, slot 64 latches.
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    latch_d = 1'b0;
    oe_n_d  = oe_n_q;
    if (cnt_q == 7'd64) begin
      sclk_d  = 1'b0;
      latch_d = 1'b1;
      oe_n_d  = 1'b0;
      cnt_d   = 7'd0;
    end else begin
      cnt_d = cnt_q + 7'd1;
      if (cnt_q == 7'd0) begin
        sh_d   = {frame_i[30:0], 1'b0};
        data_d = frame_i[31];
        sclk_d = 1'b0;
      end else if (cnt_q[0]) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        data_d = sh_q[31];
        sh_d   = {sh_q[30:0], 1'b0};
      end
    end
  end

  // Frame sequencer state and registered pin outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign sr_data_o  = data_q;
  assign sr_clk_o   = sclk_q;
  assign sr_latch_o = latch_q;
  assign sr_oe_n_o  = oe_n_q;

endmodule

// File: rtl/ag2048_tiny_calculator.sv
// 8-bit four-function keypad calculator, Tiny Tapeout pinout.
// Keypad scan, button edges, ALU and entry FSM; display via calc_sr_driver.
module ag2048_tiny_calculator
  import ag2048_calc_pkg::*;
#(
  parameter int SCAN_DIV = 8,
  parameter int DATA_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [7:0] ui_s1_q, ui_s2_q;
  logic [3:0] uio_s1_q, uio_s2_q;
  logic [6:0] btn_prev_q;
  logic [6:0] btn_s, rise;
  logic       eq_r, ac_r, ng_r, mode;
  logic [3:0] op_r;

  // Two-flop synchronizers and button edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ui_s1_q    <= '0;
      ui_s2_q    <= '0;
      uio_s1_q   <= '0;
      uio_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      ui_s1_q    <= ui_in;
      ui_s2_q    <= ui_s1_q;
      uio_s1_q   <= uio_in[3:0];
      uio_s2_q   <= uio_s1_q;
      btn_prev_q <= btn_s;
    end
  end

  assign btn_s = {ui_s2_q[7:4], uio_s2_q[2:0]};
  assign rise  = btn_s & ~btn_prev_q;
  assign eq_r  = rise[0];
  assign ac_r  = rise[1];
  assign ng_r  = rise[2];
  assign op_r  = rise[6:3];
  assign mode  = uio_s2_q[3];

  logic [1:0]    row_q;
  logic [CW-1:0] div_q;
  logic          armed_q;
  logic [1:0]    idle_q;
  logic          dig_v_q;
  logic [3:0]    dig_q;
  logic [1:0]    col;
  logic          last;
  logic [3:0]    bits;

  assign bits = ui_s2_q[3:0];
  assign last = (div_q == CW'(SCAN_DIV - 1));

  // Lowest active bit line wins.
  always_comb begin
    col = 2'd3;
    if (bits[0])      col = 2'd0;
    else if (bits[1]) col = 2'd1;
    else if (bits[2]) col = 2'd2;
  end

  // Row rotation, end-of-row sampling and one-digit-per-press gating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q   <= '0;
      div_q   <= '0;
      armed_q <= 1'b1;
      idle_q  <= '0;
      dig_v_q <= 1'b0;
      dig_q   <= '0;
    end else begin
      dig_v_q <= 1'b0;
      if (last) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
        if (|bits) begin
          idle_q  <= '0;
          armed_q <= 1'b0;
          if (armed_q) begin
            dig_v_q <= 1'b1;
            dig_q   <= {row_q, col};
          end
        end else if (idle_q == 2'd3) begin
          armed_q <= 1'b1;
        end else begin
          idle_q <= idle_q + 2'd1;
        end
      end else begin
        div_q <= div_q + CW'(1);
      end
    end
  end

  state_e            st_q;
  op_e               op_q, new_op;
  logic [DATA_W-1:0] a_q, b_q, res;
  logic              err_q;
  logic [3:0]        led_q;
  logic              div0;
  logic signed [DATA_W:0] sa, sb, sq;

  // Lowest-numbered op button wins a simultaneous press.
  always_comb begin
    new_op = OP_NONE;
    if (op_r[0])      new_op = OP_ADD;
    else if (op_r[1]) new_op = OP_SUB;
    else if (op_r[2]) new_op = OP_MUL;
    else if (op_r[3]) new_op = OP_DIV;
  end

  // ALU; signed divide widened one bit so -128/-1 wraps cleanly.
  always_comb begin
    div0 = (b_q == '0);
    sa   = {a_q[DATA_W-1], a_q};
    sb   = {b_q[DATA_W-1], b_q};
    sq   = '0;
    res  = a_q;
    unique case (op_q)
      OP_ADD: res = a_q + b_q;
      OP_SUB: res = a_q - b_q;
      OP_MUL: res = a_q * b_q;
      OP_DIV: begin
        if (div0) begin
          res = '0;
        end else if (mode) begin
          sq  = sa / sb;
          res = sq[DATA_W-1:0];
        end else begin
          res = a_q / b_q;
        end
      end
      default: res = a_q;
    endcase
  end

  // Entry FSM; AC acts like reset for everything but the scanner.
  always_ff @(posedge clk) begin
    if (!rst_n || ac_r) begin
      st_q  <= ST_ENTER_A;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      err_q <= 1'b0;
      led_q <= '0;
    end else if (eq_r) begin
      if (st_q == ST_ENTER_B && op_q != OP_NONE) begin
        a_q   <= res;
        op_q  <= OP_NONE;
        led_q <= '0;
        st_q  <= ST_RESULT;
        if (op_q == OP_DIV && div0) err_q <= 1'b1;
      end
    end else if (ng_r) begin
      if (st_q == ST_ENTER_B) b_q <= '0 - b_q;
      else                    a_q <= '0 - a_q;
    end else if (|op_r) begin
      op_q  <= new_op;
      led_q <= op_led(new_op);
      if (st_q != ST_ENTER_B) b_q <= '0;
      st_q  <= ST_ENTER_B;
    end else if (dig_v_q) begin
      unique case (st_q)
        ST_ENTER_A: a_q <= {a_q[DATA_W-5:0], dig_q};
        ST_ENTER_B: b_q <= {b_q[DATA_W-5:0], dig_q};
        default: begin
          a_q  <= DATA_W'(dig_q);
          st_q <= ST_ENTER_A;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] val, mag;
  logic              neg;
  logic [31:0]       frame;

  // Display frame: sign, blank, two hex digits of the magnitude.
  always_comb begin
    val = (st_q == ST_ENTER_B) ? b_q : a_q;
    neg = mode && val[DATA_W-1];
    mag = neg ? ('0 - val) : val;
    if (err_q) begin
      frame = {4{SEG_MINUS}};
    end else begin
      frame = {neg ? SEG_MINUS : SEG_BLANK, SEG_BLANK,
               seg_hex(mag[7:4]), seg_hex(mag[3:0])};
    end
  end

  logic sr_data, sr_clk, sr_latch, sr_oe_n;

  calc_sr_driver u_sr (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_i    (frame),
    .sr_data_o  (sr_data),
    .sr_clk_o   (sr_clk),
    .sr_latch_o (sr_latch),
    .sr_oe_n_o  (sr_oe_n)
  );

  assign uo_out  = {sr_oe_n, sr_latch, sr_clk, sr_data, 4'b0001 << row_q};
  assign uio_out = {led_q, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in[7:4]};

endmodule

// File: tb/tb_ag2048_tiny_calculator.sv
// Bench for ag2048_tiny_calculator.
// Keypad model, frame monitor and display scoreboard.
module tb_ag2048_tiny_calculator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key = '0;
  logic [3:0] ops = '0;
  logic [2:0] ctl = '0;
  logic       mode = 1'b0;
  wire  [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  wire  [3:0] kbits;

  always #5 clk = ~clk;

  assign kbits  = (key[4] && uo_out[key[3:2]]) ? (4'b0001 << key[1:0]) : 4'b0000;
  assign ui_in  = {ops, kbits};
  assign uio_in = {4'b0000, mode, ctl};

  ag2048_tiny_calculator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] SEG [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                           8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'hEE, 8'h3E,
                           8'h9C, 8'h7A, 8'h9E, 8'h8E};

  function automatic logic [31:0] dfrm(logic [7:0] v, bit m, bit e);
    logic [7:0] g;
    logic       n;
    if (e) return 32'h02020202;
    n = m && v[7];
    g = n ? (~v + 8'd1) : v;
    return {n ? 8'h02 : 8'h00, 8'h00, SEG[g[7:4]], SEG[g[3:0]]};
  endfunction

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] frame_sh = '0;
  logic        prev_sclk = 1'b0;
  int          skip = 0;

  always @(negedge clk) begin
    if (uo_out[5] && !prev_sclk) frame_sh = {frame_sh[30:0], uo_out[4]};
    prev_sclk = uo_out[5];
    if (uo_out[6]) begin
      if (skip > 0) skip--;
      else if (exp_q.size() > 0) chk(tag_q.pop_front(), frame_sh, exp_q.pop_front());
    end
  end

  task automatic disp(string tag, logic [31:0] e);
    @(posedge clk);
    skip = 1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic press_key(logic [3:0] k, int hold);
    @(negedge clk);
    key = {1'b1, k};
    repeat (hold) @(negedge clk);
    key = '0;
    repeat (50) @(negedge clk);
  endtask

  task automatic keys(logic [3:0] k1, logic [3:0] k0);
    press_key(k1, 70);
    press_key(k0, 70);
  endtask

  task automatic btn_op(int i);
    @(negedge clk);
    ops[i] = 1'b1;
    repeat (4) @(negedge clk);
    ops = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic btn_ctl(int i);
    @(negedge clk);
    ctl[i] = 1'b1;
    repeat (4) @(negedge clk);
    ctl = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_mode(logic m);
    @(negedge clk);
    mode = m;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_oe", {24'd0, uio_oe}, 32'hF0);
    chk("rst_led", {24'd0, uio_out}, 32'h00);
    chk("rst_uo", {24'd0, uo_out}, 32'h81);
    rst_n = 1'b1;
    disp("rst_disp", dfrm(8'h00, 0, 0));
    chk("oe_n_low", {31'd0, uo_out[7]}, 32'd0);

    keys(4'h1, 4'h2);
    disp("entry_a", dfrm(8'h12, 0, 0));
    btn_op(0);
    chk("led_add", {24'd0, uio_out}, 32'h10);
    disp("b_cleared", dfrm(8'h00, 0, 0));
    keys(4'h3, 4'h4);
    disp("entry_b", dfrm(8'h34, 0, 0));
    chk("led_add_b", {24'd0, uio_out}, 32'h10);
    btn_ctl(0);
    disp("add_res", dfrm(8'h46, 0, 0));
    chk("led_none", {24'd0, uio_out}, 32'h00);

    btn_ctl(1);
    set_mode(1'b1);
    keys(4'h0, 4'h5);
    btn_op(1);
    keys(4'h0, 4'h7);
    btn_ctl(0);
    disp("sub_m1", dfrm(8'hFE, 1, 0));
    set_mode(1'b0);
    disp("sub_m0", dfrm(8'hFE, 0, 0));

    btn_ctl(1);
    set_mode(1'b1);
    keys(4'h8, 4'h0);
    btn_op(3);
    chk("led_div", {24'd0, uio_out}, 32'h80);
    keys(4'h0, 4'h2);
    btn_ctl(0);
    disp("div_s", dfrm(8'hC0, 1, 0));

    btn_ctl(1);
    set_mode(1'b0);
    keys(4'h8, 4'h0);
    btn_op(3);
    keys(4'h0, 4'h2);
    btn_ctl(0);
    disp("div_u", dfrm(8'h40, 0, 0));

    btn_ctl(1);
    press_key(4'h9, 70);
    btn_op(3);
    press_key(4'h0, 70);
    btn_ctl(0);
    disp("div0", dfrm(8'h00, 0, 1));
    btn_ctl(1);
    disp("ac_clear", dfrm(8'h00, 0, 0));
    chk("ac_led", {24'd0, uio_out}, 32'h00);

    press_key(4'h5, 110);
    disp("hold_once", dfrm(8'h05, 0, 0));
    btn_ctl(2);
    disp("neg", dfrm(8'hFB, 0, 0));

    btn_op(2);
    chk("led_mul", {24'd0, uio_out}, 32'h40);
    press_key(4'h2, 70);
    btn_ctl(0);
    disp("mul", dfrm(8'hF6, 0, 0));
    btn_op(0);
    press_key(4'hF, 70);
    btn_ctl(0);
    disp("chain", dfrm(8'h05, 0, 0));

    btn_op(1);
    chk("led_sub", {24'd0, uio_out}, 32'h20);
    repeat (23) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_uo", {24'd0, uo_out}, 32'h81);
    chk("mid_rst_led", {24'd0, uio_out}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
